// File: rtl/qduc_pkg.sv
// Shared types and default constants for the quadrature upconverter sample feed.
package qduc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } qduc_state_t;

    localparam int QDUC_ISZ           = 16;
    localparam int QDUC_RATIO_W       = 8;
    localparam int QDUC_DEF_RATIO_M1  = 255;
    localparam int QDUC_FLUSH_STROBES = 8;
    localparam int QDUC_UCNT_W        = 16;

endpackage

// File: rtl/qduc_strobe_gen.sv
// Loadable down-counter: stb is high when running and the count has reached
// zero, at which point the count reloads with the period-minus-one value.
module qduc_strobe_gen #(
    parameter int RATIO_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [RATIO_W-1:0] ratio,
    output logic               stb
);

    logic [RATIO_W-1:0] cnt_reg;

    assign stb = run && (cnt_reg == '0);

    // Count parks at zero while not running so the first strobe after
    // entering RUN fires on the very first running cycle.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt_reg <= '0;
        end else if (stb) begin
            cnt_reg <= ratio;
        end else begin
            cnt_reg <= cnt_reg - RATIO_W'(1);
        end
    end

endmodule

// File: rtl/qduc_feed_ctrl.sv
// Sample feed sequencer for the quadrature upconverter: holds one host I/Q
// sample and hands it to the CIC interpolators once per interpolation period,
// with priming, zero-flush on stop and underrun accounting.
module qduc_feed_ctrl
    import qduc_pkg::*;
#(
    parameter int ISZ           = QDUC_ISZ,
    parameter int RATIO_W       = QDUC_RATIO_W,
    parameter int FLUSH_STROBES = QDUC_FLUSH_STROBES,
    parameter int UCNT_W        = QDUC_UCNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [RATIO_W-1:0] ratio_m1,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [ISZ-1:0]     s_i,
    input  logic [ISZ-1:0]     s_q,
    output logic               cic_stb,
    output logic [ISZ-1:0]     cic_i,
    output logic [ISZ-1:0]     cic_q,
    output logic               active,
    output logic               underrun,
    output logic [UCNT_W-1:0]  underrun_cnt,
    input  logic               underrun_clr
);

    localparam int FW = $clog2(FLUSH_STROBES + 1);

    qduc_state_t        state_reg;
    logic               pending_reg;
    logic [ISZ-1:0]     held_i_reg, held_q_reg;
    logic [ISZ-1:0]     cic_i_reg, cic_q_reg;
    logic               cic_stb_reg;
    logic [RATIO_W-1:0] ratio_q_reg;
    logic [FW-1:0]      flush_cnt_reg;
    logic               underrun_reg;
    logic [UCNT_W-1:0]  ucnt_reg;

    logic run;
    logic stb_now;
    logic accept;
    logic underrun_evt;

    assign run = (state_reg == RUN) || (state_reg == DRAIN);

    qduc_strobe_gen #(
        .RATIO_W (RATIO_W)
    ) u_strobe_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .ratio (ratio_q_reg),
        .stb   (stb_now)
    );

    // Ready while priming, or in RUN when the holding slot is free or is being
    // emptied by this cycle's strobe (lets ratio 1 sustain a sample per clock).
    // Gated by enable so a sample is never swallowed on the way out.
    always_comb begin
        s_ready = 1'b0;
        if (state_reg == PRIME) begin
            s_ready = enable;
        end else if (state_reg == RUN) begin
            s_ready = enable && (!pending_reg || stb_now);
        end
    end

    assign accept       = s_valid && s_ready;
    assign underrun_evt = stb_now && (state_reg == RUN) && !pending_reg;

    assign cic_stb      = cic_stb_reg;
    assign cic_i        = cic_i_reg;
    assign cic_q        = cic_q_reg;
    assign active       = (state_reg != IDLE);
    assign underrun     = underrun_reg;
    assign underrun_cnt = ucnt_reg;

    // Underrun flag and saturating counter; a fresh underrun beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_reg <= 1'b0;
            ucnt_reg     <= '0;
        end else if (underrun_evt) begin
            underrun_reg <= 1'b1;
            if (underrun_clr) begin
                ucnt_reg <= UCNT_W'(1);
            end else if (ucnt_reg != '1) begin
                ucnt_reg <= ucnt_reg + UCNT_W'(1);
            end
        end else if (underrun_clr) begin
            underrun_reg <= 1'b0;
            ucnt_reg     <= '0;
        end
    end

    // Main sequencer: state, holding slot and registered CIC outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            held_i_reg    <= '0;
            held_q_reg    <= '0;
            cic_i_reg     <= '0;
            cic_q_reg     <= '0;
            cic_stb_reg   <= 1'b0;
            ratio_q_reg   <= '0;
            flush_cnt_reg <= '0;
        end else begin
            cic_stb_reg <= stb_now;
            case (state_reg)
                IDLE: begin
                    pending_reg   <= 1'b0;
                    flush_cnt_reg <= '0;
                    if (enable) begin
                        ratio_q_reg <= ratio_m1;
                        state_reg   <= PRIME;
                    end
                end
                PRIME: begin
                    if (!enable) begin
                        state_reg <= IDLE;
                    end else if (accept) begin
                        held_i_reg  <= s_i;
                        held_q_reg  <= s_q;
                        pending_reg <= 1'b1;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (stb_now) begin
                        cic_i_reg <= pending_reg ? held_i_reg : '0;
                        cic_q_reg <= pending_reg ? held_q_reg : '0;
                    end
                    if (!enable) begin
                        pending_reg   <= 1'b0;
                        flush_cnt_reg <= '0;
                        state_reg     <= DRAIN;
                    end else if (accept) begin
                        held_i_reg  <= s_i;
                        held_q_reg  <= s_q;
                        pending_reg <= 1'b1;
                    end else if (stb_now) begin
                        pending_reg <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (stb_now) begin
                        cic_i_reg <= '0;
                        cic_q_reg <= '0;
                        if (flush_cnt_reg == FW'(FLUSH_STROBES - 1)) begin
                            flush_cnt_reg <= '0;
                            pending_reg   <= 1'b0;
                            state_reg     <= IDLE;
                        end else begin
                            flush_cnt_reg <= flush_cnt_reg + FW'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qduc_feed_ctrl.sv
// Directed bench for the upconverter sample feed sequencer.
module tb_qduc_feed_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  ratio_m1;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_i, s_q;
    logic        cic_stb;
    logic [15:0] cic_i, cic_q;
    logic        active;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        underrun_clr;

    int vectors = 0;
    int miscompares = 0;

    qduc_feed_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ratio_m1     (ratio_m1),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_i          (s_i),
        .s_q          (s_q),
        .cic_stb      (cic_stb),
        .cic_i        (cic_i),
        .cic_q        (cic_q),
        .active       (active),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        logic [15:0] k, expv, negk;
        int since, seen, zeros, stall, n, strobes;
        bit stall_done, acc, found;

        reset = 1'b1; enable = 1'b0; ratio_m1 = 8'd0; s_valid = 1'b0;
        s_i = '0; s_q = '0; underrun_clr = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_s_ready", s_ready, 0);
        check("rst_cic_stb", cic_stb, 0);
        check("rst_cic_i", cic_i, 0);
        check("rst_cic_q", cic_q, 0);
        check("rst_active", active, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ucnt", underrun_cnt, 0);
        reset = 1'b0;

        // Ratio 256: single sample, latency 2 edges, next strobe 256 later
        enable = 1'b1; ratio_m1 = 8'd255;
        tick();
        check("t1_active", active, 1);
        s_valid = 1'b1; s_i = 16'h1234; s_q = 16'hFFFB;
        check("t1_ready_prime", s_ready, 1);
        tick();
        s_valid = 1'b0;
        check("t1_no_stb_yet", cic_stb, 0);
        tick();
        check("t1_stb", cic_stb, 1);
        check("t1_cic_i", cic_i, 16'h1234);
        check("t1_cic_q", cic_q, 16'hFFFB);
        n = 0; found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            tick(); n++;
            if (cic_stb) found = 1;
        end
        check("t1_found", found, 1);
        check("t1_period", n, 256);
        check("t1_ur_data", cic_i, 0);
        check("t1_ur_flag", underrun, 1);
        check("t1_ur_cnt", underrun_cnt, 1);
        reset = 1'b1; tick(); reset = 1'b0;

        // Ratio 4: continuous stream, then a 10-clock stall starting on a strobe cycle
        enable = 1'b1; ratio_m1 = 8'd3;
        tick();
        k = 16'd1; expv = 16'd1; since = 0; seen = 0; zeros = 0; stall = 0; stall_done = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc == 40) begin
                check("t2_no_underrun", underrun, 0);
                check("t2_no_ur_cnt", underrun_cnt, 0);
            end
            if (cyc >= 40 && !stall_done && seen > 0 && since == 3) begin
                stall = 10; stall_done = 1;
            end
            s_valid = (stall == 0);
            if (stall > 0) stall--;
            s_i = k; s_q = -k;
            acc = s_valid && s_ready;
            tick();
            if (acc) k++;
            if (cic_stb) begin
                if (seen > 0) check("t2_gap", since, 3);
                if (cic_i == 0 && cic_q == 0) begin
                    zeros++;
                end else begin
                    negk = -expv;
                    check("t2_i", cic_i, expv);
                    check("t2_q", cic_q, negk);
                    expv++;
                end
                seen++; since = 0;
            end else begin
                since++;
            end
            if (cyc < 40 && seen > 0) check("t2_ready", s_ready, (since == 3));
        end
        check("t3_zero_strobes", zeros, 2);
        check("t3_underrun", underrun, 1);
        check("t3_ur_cnt", underrun_cnt, 2);
        s_valid = 1'b1; s_i = k; s_q = -k;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("t3_clr_flag", underrun, 0);
        check("t3_clr_cnt", underrun_cnt, 0);

        // Drop enable just after a strobe with a sample pending: 8 zero strobes
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (cic_stb) found = 1;
        end
        check("t4_sync", found, 1);
        enable = 1'b0; s_valid = 1'b0;
        tick();
        check("t4_drain_active", active, 1);
        check("t4_drain_ready", s_ready, 0);
        strobes = 0; since = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (cic_stb) begin
                if (strobes > 0) check("t4_gap", since, 3);
                check("t4_zero_i", cic_i, 0);
                check("t4_zero_q", cic_q, 0);
                strobes++; since = 0;
            end else begin
                since++;
            end
        end
        check("t4_flush_count", strobes, 8);
        check("t4_idle_active", active, 0);
        check("t4_idle_ready", s_ready, 0);

        // Reset in the middle of DRAIN
        enable = 1'b1; ratio_m1 = 8'd3;
        tick();
        s_valid = 1'b1; s_i = 16'h0042; s_q = 16'h0043;
        tick();
        s_valid = 1'b0;
        tick();
        check("t5_stb", cic_stb, 1);
        enable = 1'b0;
        repeat (10) tick();
        check("t5_in_drain", active, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_stb", cic_stb, 0);
        check("t5_rst_i", cic_i, 0);
        check("t5_rst_q", cic_q, 0);
        check("t5_rst_active", active, 0);
        check("t5_rst_ready", s_ready, 0);
        check("t5_rst_ur", underrun, 0);
        check("t5_rst_ucnt", underrun_cnt, 0);
        strobes = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (cic_stb) strobes++;
        end
        check("t5_no_strobes", strobes, 0);

        // Ratio 1: strobe every clock with no underruns while fed, then saturation
        enable = 1'b1; ratio_m1 = 8'd0;
        tick();
        k = 16'd100; expv = 16'd100; seen = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            s_valid = 1'b1; s_i = k; s_q = ~k;
            acc = s_ready;
            tick();
            if (acc) k++;
            if (cyc >= 1) begin
                check("t6_stb_every_clk", cic_stb, 1);
                check("t6_i", cic_i, expv);
                expv++;
            end
        end
        check("t6_no_underrun", underrun_cnt, 0);
        s_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 70000 && !found; c++) begin
            tick();
            if (underrun_cnt == 16'hFFFF) found = 1;
        end
        check("t6_reached_max", found, 1);
        tick();
        check("t6_extra_stb", cic_stb, 1);
        check("t6_extra_zero", cic_i, 0);
        check("t6_sat_cnt", underrun_cnt, 16'hFFFF);
        check("t6_sat_flag", underrun, 1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("t6_clr_vs_new", underrun_cnt, 1);
        check("t6_clr_vs_new_flag", underrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
